// File: rtl/inst_sram_responder_if.sv
// Fetch-side and backing-memory-side signals of the instruction SRAM responder.
// The slave modport is the responder; the master modport is the fetch stage plus memory.
interface inst_sram_responder_if;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        inst_stall;
   logic        inst_flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   modport master (
      output inst_sram_en, inst_sram_addr, inst_flush,
      output mem_addr_ok, mem_data_ok, mem_rdata,
      input  inst_sram_rdata, inst_stall, mem_req, mem_addr
   );

   modport slave (
      input  inst_sram_en, inst_sram_addr, inst_flush,
      input  mem_addr_ok, mem_data_ok, mem_rdata,
      output inst_sram_rdata, inst_stall, mem_req, mem_addr
   );
endinterface

// File: rtl/inst_sram_responder.sv
// Single-entry instruction fetch buffer: combinational hits, and a one-outstanding
// req/addr_ok/data_ok miss handshake to backing memory with flush-driven discard.
module inst_sram_responder #(
   parameter logic [31:0] reset_addr = 32'hbfc00000
) (
   input  logic                  clk,
   input  logic                  rst,
   inst_sram_responder_if.slave  bus
);
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      IDLE = 2'd1,
      REQ  = 2'd2,
      WAIT = 2'd3
   } state_t;

   state_t      state_r, state_next_s;
   logic [31:0] pend_addr_r, pend_next_s;
   logic        drop_r, drop_next_s;
   logic        buf_valid_r;
   logic [29:0] buf_tag_r;
   logic [31:0] buf_data_r;
   logic        mem_req_r;
   logic [31:0] mem_addr_r;
   logic        hit_s, done_s, fill_s, busy_s;
   logic        unused_s;

   // Hits are suppressed during reset and flush so the stall never lies about stale data.
   assign hit_s = buf_valid_r & ~rst & ~bus.inst_flush &
                  (buf_tag_r == bus.inst_sram_addr[31:2]);
   assign bus.inst_stall      = bus.inst_sram_en & ~hit_s;
   assign bus.inst_sram_rdata = rst ? 32'd0 : buf_data_r;
   assign bus.mem_req         = mem_req_r;
   assign bus.mem_addr        = mem_addr_r;
   assign busy_s              = (state_r == REQ) | (state_r == WAIT);
   assign unused_s            = ^bus.inst_sram_addr[1:0];

   // Next-state, pending address and drop-flag logic.
   always_comb begin
      state_next_s = state_r;
      pend_next_s  = pend_addr_r;
      drop_next_s  = drop_r;
      done_s       = 1'b0;
      fill_s       = 1'b0;
      case (state_r)
         BOOT: begin
            state_next_s = REQ;
            pend_next_s  = reset_addr;
         end
         IDLE: begin
            if (bus.inst_sram_en & ~hit_s & ~bus.inst_flush) begin
               state_next_s = REQ;
               pend_next_s  = {bus.inst_sram_addr[31:2], 2'b00};
            end else begin
               state_next_s = IDLE;
            end
         end
         REQ: begin
            if (bus.mem_addr_ok & bus.mem_data_ok) begin
               state_next_s = IDLE;
               done_s       = 1'b1;
            end else if (bus.mem_addr_ok) begin
               state_next_s = WAIT;
            end else begin
               state_next_s = REQ;
            end
         end
         WAIT: begin
            if (bus.mem_data_ok) begin
               state_next_s = IDLE;
               done_s       = 1'b1;
            end else begin
               state_next_s = WAIT;
            end
         end
         default: begin
            state_next_s = BOOT;
         end
      endcase
      // A completing transaction always clears drop so the next request is not lost.
      if (done_s) begin
         drop_next_s = 1'b0;
         fill_s      = ~drop_r;
      end else if (bus.inst_flush & busy_s) begin
         drop_next_s = 1'b1;
      end else begin
         drop_next_s = drop_r;
      end
   end

   // State, buffer and registered memory-request outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= BOOT;
         pend_addr_r <= reset_addr;
         drop_r      <= 1'b0;
         buf_valid_r <= 1'b0;
         buf_tag_r   <= 30'd0;
         buf_data_r  <= 32'd0;
         mem_req_r   <= 1'b0;
         mem_addr_r  <= 32'd0;
      end else begin
         state_r     <= state_next_s;
         pend_addr_r <= pend_next_s;
         drop_r      <= drop_next_s;
         mem_req_r   <= (state_next_s == REQ);
         mem_addr_r  <= (state_next_s == REQ) ? pend_next_s : mem_addr_r;
         buf_valid_r <= ~bus.inst_flush & (fill_s | buf_valid_r);
         if (fill_s) begin
            buf_tag_r  <= pend_addr_r[31:2];
            buf_data_r <= bus.mem_rdata;
         end
      end
   end
endmodule

// File: doc/inst_sram_responder.md
# inst_sram_responder

Instruction-side memory responder that services the fetch stage's `inst_sram_*` request port. It holds a single-entry fetch buffer (tag + word). It answers hits combinationally. On a miss it runs a multi-cycle request/address-ok/data-ok handshake to the backing instruction memory and raises `inst_stall` until the word is available. The fetch stage keeps `IRWrite` low while `inst_stall` is high.

## Interface
- `reset_addr`, default 32'hbfc00000: address of the boot fetch issued automatically after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_sram_en`  in  1  fetch request valid.
- `inst_sram_addr`  in  32  fetch byte address; bits [1:0] ignored.
- `inst_sram_rdata`  out  32  instruction word; valid when `inst_sram_en & ~inst_stall`.
- `inst_stall`  out  1  requested word not yet available.
- `inst_flush`  in  1  invalidate buffer and discard any in-flight response (exception or eret).
- `mem_req`  out  1  backing-memory request valid.
- `mem_addr`  out  32  word-aligned request address; bits [1:0] = 0.
- `mem_addr_ok`  in  1  memory accepted the request this cycle.
- `mem_data_ok`  in  1  `mem_rdata` is valid this cycle.
- `mem_rdata`  in  32  returned word.

## Operation
- Buffer: `buf_valid`, `buf_tag[29:0]`, `buf_data[31:0]`.
- Hit when `buf_valid & (buf_tag == inst_sram_addr[31:2]) & ~inst_flush`.
- `inst_stall = inst_sram_en & ~hit`. This is combinational, so it is 0 whenever `inst_sram_en` is 0.
- `inst_sram_rdata = buf_data` at all times. It is 32'd0 after reset until the first fill.
- FSM states:
  - BOOT: after reset, request `reset_addr`.
  - IDLE
  - REQ: `mem_req` = 1 and `mem_addr` is held stable until `mem_addr_ok`.
  - WAIT: waiting for `mem_data_ok`.
- Transitions:
  - BOOT -> REQ, with `pend_addr` = `reset_addr`.
  - IDLE -> REQ when `inst_sram_en & ~hit & ~inst_flush`; latch `pend_addr` = {`inst_sram_addr[31:2]`, 2'b00}.
  - REQ -> WAIT on `mem_addr_ok`. If `mem_addr_ok` and `mem_data_ok` are both high in the same cycle, go REQ -> IDLE and fill in that cycle.
  - WAIT -> IDLE on `mem_data_ok`. Fill sets `buf_tag` = `pend_addr[31:2]`, `buf_data` = `mem_rdata`, `buf_valid` = 1.
- Exactly one outstanding request. `mem_data_ok` outside WAIT (or the REQ same-cycle case) is ignored.
- Address change during REQ/WAIT: the pending request completes and fills with `pend_addr`. Next cycle the new address misses and starts a new request.
- `inst_flush`:
  - Clears `buf_valid` at the next edge.
  - A flush in REQ or WAIT sets `drop` = 1. The matching `mem_data_ok` returns to IDLE without filling, then clears `drop`.
  - `mem_req` is not withdrawn once raised; REQ still waits for `mem_addr_ok`.
- Flush and fill in the same cycle: flush wins, `buf_valid` = 0.

## Timing
- Reset values: state = BOOT, `buf_valid` = 0, `buf_tag` = 0, `buf_data` = 0, `drop` = 0, `pend_addr` = `reset_addr`, `mem_req` = 0, `mem_addr` = 0.
  - While `rst` is high: `inst_stall` = `inst_sram_en`, `inst_sram_rdata` = 0.
- First cycle after reset release: BOOT. Second cycle: `mem_req` = 1, `mem_addr` = `reset_addr`.
- Hit latency: 0 cycles (combinational).
- Miss, with memory answering `mem_addr_ok` in the first REQ cycle and `mem_data_ok` one cycle later:
  - cycle 0: miss seen, `inst_stall` = 1.
  - cycle 1: REQ.
  - cycle 2: WAIT plus fill.
  - cycle 3: hit, `inst_stall` = 0.
  - Minimum miss penalty: 3 stall cycles.
- `mem_req` and `mem_addr` are registered outputs that depend only on state and `pend_addr`.
- Reset mid-operation: everything returns to reset values. A late `mem_data_ok` from the aborted request arrives while not in WAIT and is ignored.

## Test plan
- Boot: release `rst`, `inst_sram_en` = 1, addr 32'hbfc00000, `mem_addr_ok` immediate, `mem_data_ok` 1 cycle later with 32'h3c1d0000. Required: `mem_req` seen with `mem_addr` 32'hbfc00000; `inst_stall` falls and `inst_sram_rdata` = 32'h3c1d0000.
- Sequential misses: addrs 32'hbfc00004 then 32'hbfc00008. Memory latency 3 cycles after `mem_addr_ok`. Required: one `mem_req` per address; stall lasts 5 cycles each; correct word per address.
- Hit: re-present 32'hbfc00008 on the cycle after its fill. Required: `inst_stall` = 0 immediately and no `mem_req`.
- Address change in WAIT: switch addr from 32'hbfc00010 to 32'hbfc00100. Required: the buffer fills tag for ...10, a second request goes to 32'hbfc00100, and the final rdata is the ...100 word.
- Flush in WAIT: `inst_flush` pulses while waiting on 32'hbfc00020. Required: the returned word is discarded, `buf_valid` = 0, and the re-presented ...20 issues a fresh `mem_req`.
- Same-cycle `mem_addr_ok` & `mem_data_ok` with 32'h12345678. Required: fill occurs, REQ -> IDLE, hit on the next cycle.
